// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared constants for the mul_seq32 sequential multiplier.
//               Holds the iteration count, the counter width, the FSM state
//               encodings and the operand magnitude helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  // One shift-add step per multiplier bit
  localparam int MUL_ITER = 32;
  localparam int CNT_W    = 6;

  // FSM encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Two's-complement magnitude. 0x80000000 maps to itself, which is exactly
  // 2^31 when the result is read as unsigned, so the most negative operand
  // needs no special case.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_seq32_adder32.sv
`default_nettype none
// ============================================================================
// Module      : Adder32
// Description : 32-bit ripple-style adder with carry-in and carry-out.
// Ports       : A, B  - 32-bit addends
//               Ci    - carry in
//               S     - 32-bit sum
//               Co    - carry out
// Revision    : 1.0 - initial release
// ============================================================================
module Adder32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Ci,
  output logic [31:0] S,
  output logic        Co
);

  assign {Co, S} = {1'b0, A} + {1'b0, B} + {32'd0, Ci};

endmodule
`default_nettype wire

// File: rtl/mul_seq32.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq32
// Description : Sequential 32x32 -> 64 shift-add multiplier. Operands are
//               reduced to magnitudes at start, 32 shift-add iterations build
//               the unsigned product, and a final FIX cycle applies the sign.
// Parameters  : SIGNED_EN - 1 honours sgn, 0 forces unsigned operation
// Ports       : clk   - clock, rising edge
//               rst   - asynchronous active-high reset
//               start - launch request, sampled in IDLE only
//               sgn   - 1 = operands are two's-complement signed
//               A, B  - 32-bit multiplicand / multiplier
//               busy  - high while not IDLE
//               done  - one-cycle pulse when P is updated
//               P     - 64-bit product, held until next completion/reset
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq32 #(
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [63:0] P
);

  import mul_pkg::*;

  logic [1:0]       state_q, state_d;
  logic [31:0]      mcand_q, mcand_d;
  logic [31:0]      mq_q,    mq_d;
  logic [31:0]      acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             neg_q,   neg_d;
  logic [63:0]      p_q,     p_d;

  logic             w_signed;
  logic [31:0]      w_addend;
  logic [31:0]      w_sum;
  logic             w_co;
  logic [63:0]      w_raw;

  assign w_signed = SIGNED_EN & sgn;
  assign w_addend = mq_q[0] ? mcand_q : 32'd0;
  assign w_raw    = {acc_q, mq_q};

  Adder32 u_adder (
    .A  (acc_q),
    .B  (w_addend),
    .Ci (1'b0),
    .S  (w_sum),
    .Co (w_co)
  );

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mq_d    = mq_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          mcand_d = w_signed ? abs32(A) : A;
          mq_d    = w_signed ? abs32(B) : B;
          acc_d   = 32'd0;
          cnt_d   = '0;
          neg_d   = w_signed & (A[31] ^ B[31]);
        end
      end
      S_CALC: begin
        // {carry, sum, mq} >> 1: carry-out becomes the new acc MSB and the
        // sum LSB drops into the vacated top bit of mq.
        acc_d = {w_co, w_sum[31:1]};
        mq_d  = {w_sum[0], mq_q[31:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MUL_ITER - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        p_d     = neg_q ? (~w_raw + 64'd1) : w_raw;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mcand_q <= 32'd0;
      mq_q    <= 32'd0;
      acc_q   <= 32'd0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      p_q     <= 64'd0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mq_q    <= mq_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign P    = p_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq32.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq32
// Description : Directed bench for mul_seq32. A signed-capable instance and
//               an unsigned-only instance share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy_s, done_s, busy_u, done_u;
  logic [63:0] p_s, p_u;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mul_seq32 #(.SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .A(a_in), .B(b_in),
    .busy(busy_s), .done(done_s), .P(p_s)
  );

  mul_seq32 #(.SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .A(a_in), .B(b_in),
    .busy(busy_u), .done(done_u), .P(p_u)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One operation: start is driven for a single edge (edge 1), optionally a
  // second start with other operands is injected while busy. Runs 40 edges,
  // recording the signed instance's done edge, busy cycles, done count and
  // the P of both instances when their done pulse is seen.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at,
                        output logic [63:0] ps, output logic [63:0] pu,
                        output int done_edge, output int busy_n, output int dcnt);
    int e;
    ps = '0; pu = '0; done_edge = 0; busy_n = 0; dcnt = 0;
    @(negedge clk);
    start = 1'b1; sgn = s; a_in = a; b_in = b;
    e = 0;
    repeat (40) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      start = 1'b0;
      a_in = $urandom; b_in = $urandom; sgn = $urandom_range(0, 1);
      if (inject_at != 0 && e == inject_at - 1) begin
        start = 1'b1; a_in = 32'd9; b_in = 32'd9;
      end
      if (busy_s) busy_n++;
      if (done_s) begin
        dcnt++;
        if (done_edge == 0) done_edge = e;
        ps = p_s;
      end
      if (done_u) pu = p_u;
    end
  endtask

  logic [63:0] ps, pu;
  int de, bn, dc;
  int pulses, first_e, second_e, e;

  initial begin
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a_in = '0; b_in = '0;
    #12;
    chk("reset_busy", {63'd0, busy_s}, 64'd0);
    chk("reset_done", {63'd0, done_s}, 64'd0);
    chk("reset_P",    p_s,             64'd0);
    @(negedge clk); rst = 1'b0;

    // Unsigned all-ones: exercises carry-out of the accumulate
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, ps, pu, de, bn, dc);
    chk("uff_P",       ps, 64'hFFFF_FFFE_0000_0001);
    chk("uff_P_u",     pu, 64'hFFFF_FFFE_0000_0001);
    chk("uff_done_at", 64'(de), 64'd34);
    chk("uff_busy_n",  64'(bn), 64'd34);
    chk("uff_ndone",   64'(dc), 64'd1);

    // -3 * 7
    run_op(1'b1, 32'hFFFF_FFFD, 32'd7, 0, ps, pu, de, bn, dc);
    chk("s_m3x7_P",   ps, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("s_m3x7_P_u", pu, 64'h0000_0006_FFFF_FFEB);

    // most-negative squared
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 0, ps, pu, de, bn, dc);
    chk("s_min2_P",   ps, 64'h4000_0000_0000_0000);
    chk("s_min2_P_u", pu, 64'h4000_0000_0000_0000);

    // max positive times most negative
    run_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 0, ps, pu, de, bn, dc);
    chk("s_maxmin_P",   ps, 64'hC000_0000_8000_0000);
    chk("s_maxmin_P_u", pu, 64'h3FFF_FFFF_8000_0000);

    // start while busy at cycle 10 is ignored
    run_op(1'b0, 32'd5, 32'd6, 10, ps, pu, de, bn, dc);
    chk("busy_start_P",     ps, 64'd30);
    chk("busy_start_ndone", 64'(dc), 64'd1);
    chk("busy_start_at",    64'(de), 64'd34);

    // Reset during CALC iteration 10
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a_in = 32'h1234_5678; b_in = 32'd9;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", {63'd0, busy_s}, 64'd0);
    chk("rst_mid_done", {63'd0, done_s}, 64'd0);
    chk("rst_mid_P",    p_s,             64'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    run_op(1'b0, 32'd3, 32'd4, 0, ps, pu, de, bn, dc);
    chk("post_rst_P",  ps, 64'd12);
    chk("post_rst_at", 64'(de), 64'd34);

    // sgn ignored by the unsigned-only instance
    run_op(1'b1, 32'hFFFF_FFFF, 32'd2, 0, ps, pu, de, bn, dc);
    chk("u_ign_sgn_P_u", pu, 64'h0000_0001_FFFF_FFFE);
    chk("u_ign_sgn_P_s", ps, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(1'b1, 32'd0, 32'hDEAD_BEEF, 0, ps, pu, de, bn, dc);
    chk("u_zero_P_u", pu, 64'd0);
    chk("u_zero_P_s", ps, 64'd0);

    // start held for 100 cycles: completions 35 cycles apart
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a_in = 32'd2; b_in = 32'd3;
    pulses = 0; first_e = 0; second_e = 0; e = 0;
    repeat (100) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      if (done_s) begin
        pulses++;
        if (pulses == 1) first_e = e;
        if (pulses == 2) second_e = e;
        chk("b2b_P", p_s, 64'd6);
      end
    end
    start = 1'b0;
    chk("b2b_pulses", 64'(pulses),   64'd2);
    chk("b2b_first",  64'(first_e),  64'd34);
    chk("b2b_second", 64'(second_e), 64'd69);
    repeat (40) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_seq32.md
MUL_SEQ32 -- requirements
Module: mul_seq32

Interface
REQ-001 The block SHALL have parameter SIGNED_EN, default 1; 1 = sgn input honoured, 0 = sgn ignored and all operations unsigned.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request a multiply; sampled only in IDLE.
REQ-005 sgn  in  1  1 = A, B two's-complement signed; 0 = unsigned.
REQ-006 A  in  32  multiplicand, sampled with start.
REQ-007 B  in  32  multiplier, sampled with start.
REQ-008 busy  out  1  high whenever state is not IDLE.
REQ-009 done  out  1  single-cycle pulse; P valid.
REQ-010 P  out  64  product; holds its value until the next completion or reset.

Function
REQ-011 The state machine SHALL have the states IDLE, CALC, FIX and DONE, with transitions IDLE->CALC on start, CALC->FIX after 32 iterations, FIX->DONE and DONE->IDLE unconditionally.
REQ-012 On the edge sampling start=1 in IDLE, the block SHALL latch the operands, clear the upper 32-bit accumulator and clear the 6-bit iteration counter.
- Latched operands: mcand = |A| and mq = |B| when signed, otherwise A and B.
- Signed mode: sgn=1 and SIGNED_EN=1.
- neg = A[31]^B[31] when signed, otherwise 0.
REQ-013 In each CALC cycle, sum = acc_hi + (mq[0] ? mcand : 0) SHALL be formed with a 33rd bit equal to the adder carry-out, and then {carry, sum, mq} SHALL shift right one bit into {acc_hi, mq}.
REQ-014 CALC SHALL last exactly 32 cycles, with the counter incrementing per cycle and the exit taken when the counter equals 31.
REQ-015 FIX SHALL load P with the 64-bit two's-complement negation of {acc_hi, mq} when neg=1, and with {acc_hi, mq} otherwise.
REQ-016 done SHALL be high for exactly one cycle (state DONE), asserted after the 34th rising edge counting the start-sampling edge as the 1st.
REQ-017 A start asserted while busy=1 SHALL be ignored, with no operand latch and no effect on the in-flight result.
REQ-018 A start held high continuously SHALL launch a new operation on the first IDLE cycle after DONE, giving a back-to-back interval of 35 cycles.
REQ-019 The product SHALL be exact for all operands, including 0x80000000 signed (|x| = 2^31 as unsigned) and 0xFFFFFFFF unsigned.
REQ-020 A, B and sgn SHALL be don't-care outside the start-sampling edge.

Reset
REQ-021 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, P=0, accumulator, mq, counter and neg to 0, regardless of the clock.
REQ-022 A reset asserted mid-operation SHALL abort the operation with no done pulse, and the first start after reset deasserts SHALL behave as from power-up.

Structure
REQ-023 The state encodings and the constant MUL_ITER=32 SHALL reside in the shared package mul_pkg.
REQ-024 The accumulate SHALL instantiate the existing Adder32 as the one sub-module (Ci=0), with its Co used as the 33rd sum bit.
REQ-025 Operand absolute value and the FIX negation SHALL be local logic and SHALL NOT use additional adder instances.

Verification
REQ-026 sgn=0, A=B=0xFFFFFFFF -> P=0xFFFFFFFE_00000001, done on the 34th edge, busy high for 34 cycles (exercises carry-out).
REQ-027 sgn=1, A=0xFFFFFFFD (-3), B=7 -> P=0xFFFFFFFF_FFFFFFEB (-21); sgn=1, A=B=0x80000000 -> P=0x40000000_00000000.
REQ-028 start A=5, B=6, then start A=9, B=9 at cycle 10 while busy -> P=30, only one done pulse.
REQ-029 rst pulsed during CALC iteration 10 -> busy=0, done=0, P=0 asynchronously; next start A=3, B=4 -> P=12.
REQ-030 SIGNED_EN=0, sgn=1, A=0xFFFFFFFF, B=2 -> P=0x00000001_FFFFFFFE; A=0, B=0xDEADBEEF -> P=0.
REQ-031 start held high for 100 cycles with A=2, B=3 -> done pulses 35 cycles apart, P=6 each time.
